ts_symbol_pack_fifo: RTL and testbench

//  Parametrised packing FIFO for the TS recorder datapath: stores SYM_W-bit symbols SPW=MEM_W/SYM_W per MEM_W-bit memory word.

---
 rtl/ts_symbol_pack_fifo.sv | 169 ++++++++++++++++
 tb/tb_ts_symbol_pack_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ts_symbol_pack_fifo.sv
// rtl/ts_symbol_pack_fifo.sv - packing FIFO storing SPW SYM_W-bit symbols per MEM_W-bit memory word.
// Optional sticky error flags: define PACK_FIFO_STICKY_ERR_EN.
module ts_symbol_pack_fifo #(
    parameter int SYM_W = 10,
    parameter int MEM_W = 32,
    parameter int DEPTH = 16,
    localparam int SPW  = MEM_W / SYM_W,
    localparam int CAP  = DEPTH * SPW,
    localparam int CW   = $clog2(CAP + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             WRITE_IN,
    input  logic [SYM_W-1:0] DATA_IN,
    input  logic             READ_IN,
    output logic [SYM_W-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CW-1:0]    COUNT,
`ifdef PACK_FIFO_STICKY_ERR_EN
    input  logic             CLEAR_ERR,
    output logic [1:0]       ERR_STICKY,
`endif
    output logic             OVF_PULSE,
    output logic             UNF_PULSE
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [MEM_W-1:0] ONE_W = {{(MEM_W-1){1'b0}}, 1'b1};
    // Bits above the last whole symbol; zero when symbols tile the word exactly.
    localparam logic [MEM_W-1:0] PAD_MASK = ~((ONE_W << (SPW * SYM_W)) - ONE_W);

    generate
        if (SPW < 1) begin : g_bad_spw
            $error("ts_symbol_pack_fifo: MEM_W must hold at least one symbol");
        end
    endgenerate

    logic [MEM_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    waddr_q, waddr_d, raddr_q, raddr_d;
    logic [SLW-1:0]   wslot_q, wslot_d, rslot_q, rslot_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [SYM_W-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_acc, rd_acc;
    logic [MEM_W-1:0] rd_word, wr_word, wr_mask;

    always_comb begin
        wr_acc     = WRITE_IN && !full_q;
        rd_acc     = READ_IN && !empty_q;
        waddr_d    = waddr_q;
        wslot_d    = wslot_q;
        raddr_d    = raddr_q;
        rslot_d    = rslot_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        rd_word    = mem_q[raddr_q];
        wr_word    = '0;
        wr_mask    = '0;
        valid_d    = rd_acc;
        ovf_d      = WRITE_IN && !wr_acc;
        unf_d      = READ_IN && !rd_acc;

        for (int i = 0; i < SPW; i++) begin
            wr_word[i*SYM_W +: SYM_W] = DATA_IN;
            if (wslot_q == SLW'(i)) begin
                wr_mask[i*SYM_W +: SYM_W] = {SYM_W{1'b1}};
            end
            if (rd_acc && rslot_q == SLW'(i)) begin
                data_out_d = rd_word[i*SYM_W +: SYM_W];
            end
        end
        if (wslot_q == '0) begin
            wr_mask = wr_mask | PAD_MASK;
        end

        if (wr_acc) begin
            if (wslot_q == SLW'(SPW - 1)) begin
                wslot_d = '0;
                waddr_d = waddr_q + 1'b1;
            end else begin
                wslot_d = wslot_q + 1'b1;
            end
        end
        if (rd_acc) begin
            if (rslot_q == SLW'(SPW - 1)) begin
                rslot_d = '0;
                raddr_d = raddr_q + 1'b1;
            end else begin
                rslot_d = rslot_q + 1'b1;
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(CAP));
        empty_d = (count_d == '0);
    end

    // Storage is deliberately not reset; the masked write keeps the other slots intact.
    always_ff @(posedge CLOCK) begin
        if (wr_acc) begin
            mem_q[waddr_q] <= (mem_q[waddr_q] & ~wr_mask) | (wr_word & wr_mask);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            waddr_q    <= '0;
            wslot_q    <= '0;
            raddr_q    <= '0;
            rslot_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            wslot_q    <= wslot_d;
            raddr_q    <= raddr_d;
            rslot_q    <= rslot_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_VALID = valid_q;
    assign FULL       = full_q;
    assign EMPTY      = empty_q;
    assign COUNT      = count_q;
    assign OVF_PULSE  = ovf_q;
    assign UNF_PULSE  = unf_q;

`ifdef PACK_FIFO_STICKY_ERR_EN
    logic [1:0] err_q, err_d;

    // Sets on the same edge as the pulse so a clear in that cycle wins.
    always_comb begin
        err_d = CLEAR_ERR ? 2'b00 : (err_q | {ovf_d, unf_d});
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR_STICKY = err_q;
`else
    // Errors are reported through OVF_PULSE/UNF_PULSE only.
`endif
endmodule

// File: tb/tb_ts_symbol_pack_fifo.sv
// tb/tb_ts_symbol_pack_fifo.sv - queue-model and directed-vector bench for ts_symbol_pack_fifo.
module tb_ts_symbol_pack_fifo;
    localparam int SYM_W = 10;
    localparam int MEM_W = 32;
    localparam int DEPTH = 4;
    localparam int CAP   = 12;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr  = 1'b0;
    logic             rd  = 1'b0;
    logic [SYM_W-1:0] din = '0;
    logic [SYM_W-1:0] dout;
    logic             dvalid, full, empty, ovf, unf;
    logic [CW-1:0]    count;
`ifdef PACK_FIFO_STICKY_ERR_EN
    logic             clr = 1'b0;
    logic [1:0]       err_sticky;
    logic [1:0]       exp_err = 2'b00;
`endif

    int checks = 0;
    int errors = 0;

    logic [SYM_W-1:0] model_q[$];
    logic [SYM_W-1:0] exp_dout  = '0;
    logic             exp_valid = 1'b0;
    logic             exp_ovf   = 1'b0;
    logic             exp_unf   = 1'b0;

    ts_symbol_pack_fifo #(.SYM_W(SYM_W), .MEM_W(MEM_W), .DEPTH(DEPTH)) dut (
        .CLOCK(clk),
        .RESET(rst),
        .WRITE_IN(wr),
        .DATA_IN(din),
        .READ_IN(rd),
        .DATA_OUT(dout),
        .DATA_VALID(dvalid),
        .FULL(full),
        .EMPTY(empty),
        .COUNT(count),
`ifdef PACK_FIFO_STICKY_ERR_EN
        .CLEAR_ERR(clr),
        .ERR_STICKY(err_sticky),
`endif
        .OVF_PULSE(ovf),
        .UNF_PULSE(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain symbol queue with capacity CAP; flags derive from its size.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
`ifdef PACK_FIFO_STICKY_ERR_EN
            exp_err   = 2'b00;
`endif
        end else begin
            logic wa, ra;
            wa = wr && (model_q.size() < CAP);
            ra = rd && (model_q.size() > 0);
            exp_valid = ra;
            if (ra) exp_dout = model_q.pop_front();
            if (wa) model_q.push_back(din);
            exp_ovf = wr && !wa;
            exp_unf = rd && !ra;
`ifdef PACK_FIFO_STICKY_ERR_EN
            exp_err = clr ? 2'b00 : (exp_err | {exp_ovf, exp_unf});
`endif
        end
    end

    always @(negedge clk) begin
        chk("data_out", 32'(dout), 32'(exp_dout));
        chk("data_valid", 32'(dvalid), 32'(exp_valid));
        chk("count", 32'(count), model_q.size());
        chk("full", 32'(full), 32'(model_q.size() == CAP));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("ovf_pulse", 32'(ovf), 32'(exp_ovf));
        chk("unf_pulse", 32'(unf), 32'(exp_unf));
`ifdef PACK_FIFO_STICKY_ERR_EN
        chk("err_sticky", 32'(err_sticky), 32'(exp_err));
`endif
    end

    task automatic step(input logic w, input logic [SYM_W-1:0] d, input logic r);
        wr  = w;
        din = d;
        rd  = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(dout), 0);
        rst = 1'b0;

        // 1: three writes then three reads, one-cycle latency
        step(1, 10'h001, 0);
        step(1, 10'h002, 0);
        step(1, 10'h003, 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, '0, 1);
            chk("t1_dout", 32'(dout), i);
            chk("t1_valid", 32'(dvalid), 1);
        end
        step(0, '0, 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_valid_off", 32'(dvalid), 0);

        // 2: fill to capacity, overflow, drain in order
        for (int i = 0; i < CAP; i++) step(1, 10'(32'h10 + i), 0);
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 12);
        step(1, 10'h3FF, 0);
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_count_ovf", 32'(count), 12);
        for (int i = 0; i < CAP; i++) begin
            step(0, '0, 1);
            chk("t2_drain", 32'(dout), 32'h10 + i);
        end
        chk("t2_empty", 32'(empty), 1);

        // 3: underflow holds the last symbol
        step(0, '0, 1);
        chk("t3_unf", 32'(unf), 1);
        chk("t3_valid", 32'(dvalid), 0);
        chk("t3_dout_hold", 32'(dout), 32'h1B);
        chk("t3_count", 32'(count), 0);

        // 4: preload five, then concurrent traffic across address wrap
        for (int i = 0; i < 5; i++) step(1, 10'(32'h100 + i), 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 10'(32'h105 + i), 1);
            chk("t4_dout", 32'(dout), 32'h100 + i);
            chk("t4_count", 32'(count), 5);
        end

        // 5: asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) step(0, '0, 1);
        for (int i = 0; i < 4; i++) step(1, 10'(32'h50 + i), 0);
        chk("t5_count7", 32'(count), 7);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_dout", 32'(dout), 0);
        step(1, 10'h2AA, 0);
        step(0, '0, 1);
        chk("t5_readback", 32'(dout), 32'h2AA);

`ifdef PACK_FIFO_STICKY_ERR_EN
        // 6: sticky error flags
        for (int i = 0; i < CAP; i++) step(1, 10'(i), 0);
        step(1, 10'h3FF, 0);
        chk("t6_ovf_seen", 32'(err_sticky), 32'h2);
        step(0, '0, 0);
        chk("t6_ovf_held", 32'(err_sticky), 32'h2);
        clr = 1'b1;
        step(0, '0, 0);
        clr = 1'b0;
        chk("t6_cleared", 32'(err_sticky), 0);
        for (int i = 0; i < CAP; i++) step(0, '0, 1);
        clr = 1'b1;
        step(0, '0, 1);
        clr = 1'b0;
        chk("t6_unf_clr", 32'(err_sticky), 0);
        chk("t6_unf_pulse", 32'(unf), 1);
`endif

        step(0, '0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
